// File: rtl/resize_accel_bilinear_acc.sv
// Bilinear tap accumulator for the resize datapath.
// Sums TAPS unsigned weight*pixel products per output pixel, then rounds,
// shifts out the Q1.15 fraction and saturates to an OUT_W-bit pixel.
// The result is held on a valid/ready stream. tap_err is a sticky flag
// that records in_last disagreeing with the internal tap count.
module resize_accel_bilinear_acc #(
    parameter int PROD_W    = 32,
    parameter int TAPS      = 4,
    parameter int FRAC_BITS = 15,
    parameter int OUT_W     = 8,
    parameter int ACC_W     = PROD_W + 2
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic              soft_clr,
    input  logic [PROD_W-1:0] in_data,
    input  logic              in_last,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [OUT_W-1:0]  out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              tap_err,
    output logic [15:0]       pix_cnt
);

    localparam int TCW = (TAPS > 1) ? $clog2(TAPS) : 1;
    // Width of the rounded sum after the fraction is shifted out.
    localparam int RW  = ACC_W + 1 - FRAC_BITS;
    localparam logic [TCW-1:0] IDX_LAST = TCW'(TAPS - 1);
    localparam logic [TCW-1:0] IDX_PRE  = TCW'(TAPS - 2);
    localparam logic [ACC_W:0] RND_HALF = {{ACC_W{1'b0}}, 1'b1} << (FRAC_BITS - 1);

    typedef enum logic {
        ACCUM = 1'b0,   // taps 0..TAPS-2
        LAST  = 1'b1    // waiting for the final tap
    } state_t;

    // Round-half-up at ACC_W+1 bits so the add cannot wrap, then drop the fraction.
    function automatic logic [RW-1:0] round_shift(input logic [ACC_W-1:0] sum);
        logic [ACC_W:0] t;
        t = {1'b0, sum} + RND_HALF;
        return t[ACC_W:FRAC_BITS];
    endfunction

    // Clamp to the largest representable output pixel.
    function automatic logic [OUT_W-1:0] sat_pix(input logic [RW-1:0] r);
        if (|r[RW-1:OUT_W])
            return {OUT_W{1'b1}};
        else
            return r[OUT_W-1:0];
    endfunction

    state_t             r_state;
    state_t             w_state_nxt;
    logic [TCW-1:0]     r_tap_cnt;
    logic [ACC_W-1:0]   r_acc;
    logic [OUT_W-1:0]   r_out_data;
    logic               r_out_valid;
    logic               r_tap_err;
    logic [15:0]        r_pix_cnt;

    logic               w_in_ready;
    logic               w_accept;
    logic               w_final;
    logic [ACC_W-1:0]   w_sum;
    logic [OUT_W-1:0]   w_pix;

    assign w_final = (r_state == LAST);
    assign w_sum   = r_acc + {{(ACC_W-PROD_W){1'b0}}, in_data};
    assign w_pix   = sat_pix(round_shift(w_sum));

    // State register: ACCUM collects taps, LAST expects the final tap.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n)
            r_state <= ACCUM;
        else
            r_state <= w_state_nxt;
    end

    // Next state, input handshake and accept strobe.
    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b1;
        w_accept    = 1'b0;
        // Only the final tap stalls, and only while a pixel is still unconsumed.
        w_in_ready  = !(w_final && r_out_valid && !out_ready);
        // soft_clr drops the beat presented in the same cycle.
        w_accept    = in_valid && w_in_ready && !soft_clr;
        if (soft_clr) begin
            w_state_nxt = ACCUM;
        end else if (w_accept) begin
            case (r_state)
                ACCUM:   if (r_tap_cnt == IDX_PRE) w_state_nxt = LAST;
                LAST:    w_state_nxt = ACCUM;
                default: w_state_nxt = ACCUM;
            endcase
        end
    end

    // Accumulate taps, emit the finished pixel and track framing/pixel count.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_acc       <= '0;
            r_tap_cnt   <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_tap_err   <= 1'b0;
            r_pix_cnt   <= '0;
        end else if (soft_clr) begin
            r_acc       <= '0;
            r_tap_cnt   <= '0;
            r_out_valid <= 1'b0;
            r_tap_err   <= 1'b0;
            r_pix_cnt   <= '0;
        end else begin
            if (r_out_valid && out_ready)
                r_pix_cnt <= r_pix_cnt + 16'd1;

            if (w_accept) begin
                // in_last is only checked; the tap counter alone frames pixels.
                if (in_last != w_final)
                    r_tap_err <= 1'b1;
                if (w_final) begin
                    r_out_data  <= w_pix;
                    r_out_valid <= 1'b1;
                    r_acc       <= '0;
                    r_tap_cnt   <= '0;
                end else begin
                    r_acc     <= w_sum;
                    r_tap_cnt <= r_tap_cnt + TCW'(1);
                    if (r_out_valid && out_ready)
                        r_out_valid <= 1'b0;
                end
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign tap_err   = r_tap_err;
    assign pix_cnt   = r_pix_cnt;

    // The tap counter and the state must agree on where the final tap is.
    wire w_unused_idx = (r_tap_cnt == IDX_LAST);

endmodule

// File: tb/tb_resize_accel_bilinear_acc.sv
// Directed bench for resize_accel_bilinear_acc: full-scale pixel, rounding,
// saturation, back-pressure, framing error, soft clear and async reset.
module tb_resize_accel_bilinear_acc;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n;
    logic        soft_clr;
    logic [31:0] in_data;
    logic        in_last;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        tap_err;
    logic [15:0] pix_cnt;

    int checks = 0;
    int errors = 0;

    resize_accel_bilinear_acc dut (
        .ap_clk    (ap_clk),
        .ap_rst_n  (ap_rst_n),
        .soft_clr  (soft_clr),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .tap_err   (tap_err),
        .pix_cnt   (pix_cnt)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One beat presented at the negedge, accepted on the following posedge.
    task automatic beat(input logic [31:0] d, input logic last);
        @(negedge ap_clk);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        @(posedge ap_clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic pixel(input logic [31:0] d0, input logic [31:0] d1,
                         input logic [31:0] d2, input logic [31:0] d3);
        beat(d0, 1'b0);
        beat(d1, 1'b0);
        beat(d2, 1'b0);
        beat(d3, 1'b1);
    endtask

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    initial begin
        ap_rst_n  = 1'b0;
        soft_clr  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #12;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data",  32'(out_data),  0);
        chk("rst_pix_cnt",   32'(pix_cnt),   0);
        chk("rst_tap_err",   32'(tap_err),   0);
        chk("rst_in_ready",  32'(in_ready),  1);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;

        // Full-scale pixel: 4*2088960 = 8355840, (+16384)>>15 = 255.
        pixel(2088960, 2088960, 2088960, 2088960);
        chk("full_valid", 32'(out_valid), 1);
        chk("full_data",  32'(out_data),  255);
        tick();
        chk("full_pix_cnt", 32'(pix_cnt),   1);
        chk("full_drained", 32'(out_valid), 0);
        chk("full_tap_err", 32'(tap_err),   0);

        // Rounding: 16384 rounds up to 1, 16383 rounds down to 0.
        pixel(16384, 0, 0, 0);
        chk("round_up", 32'(out_data), 1);
        pixel(16383, 0, 0, 0);
        chk("round_dn_valid", 32'(out_valid), 1);
        chk("round_dn",       32'(out_data),  0);

        // Saturation: 4*0xFFFFFF rounds to 2048, clamped to 255.
        pixel(32'h00FF_FFFF, 32'h00FF_FFFF, 32'h00FF_FFFF, 32'h00FF_FFFF);
        chk("sat_data",    32'(out_data), 255);
        chk("sat_tap_err", 32'(tap_err),  0);
        tick();
        chk("sat_pix_cnt", 32'(pix_cnt), 4);

        // Back-pressure: pixel 100 held while the next pixel (50) stalls on its final tap.
        out_ready = 1'b0;
        pixel(3276800, 0, 0, 0);
        chk("bp_first_valid", 32'(out_valid), 1);
        chk("bp_first_data",  32'(out_data),  100);
        beat(1638400, 1'b0);
        beat(0, 1'b0);
        beat(0, 1'b0);
        chk("bp_hold_pix", 32'(pix_cnt), 4);
        @(negedge ap_clk);
        in_valid = 1'b1;
        in_data  = 0;
        in_last  = 1'b1;
        #1;
        chk("bp_in_ready_low", 32'(in_ready), 0);
        tick();
        chk("bp_hold_data",  32'(out_data),  100);
        chk("bp_hold_valid", 32'(out_valid), 1);
        @(negedge ap_clk);
        out_ready = 1'b1;
        #1;
        chk("bp_in_ready_high", 32'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("bp_second_valid", 32'(out_valid), 1);
        chk("bp_second_data",  32'(out_data),  50);
        chk("bp_pix_cnt_1",    32'(pix_cnt),   5);
        tick();
        chk("bp_pix_cnt_2",  32'(pix_cnt),   6);
        chk("bp_drained",    32'(out_valid), 0);

        // Framing error: in_last on tap 2; pixel still completes after 4 taps (4*327680 -> 40).
        beat(327680, 1'b0);
        beat(327680, 1'b1);
        chk("frame_err_set", 32'(tap_err),   1);
        chk("frame_no_pix",  32'(out_valid), 0);
        beat(327680, 1'b0);
        beat(327680, 1'b1);
        chk("frame_valid", 32'(out_valid), 1);
        chk("frame_data",  32'(out_data),  40);
        tick();
        chk("frame_pix_cnt", 32'(pix_cnt), 7);
        chk("frame_sticky",  32'(tap_err), 1);

        // soft_clr drops a partial pixel and clears the error and counter.
        beat(327680, 1'b0);
        beat(327680, 1'b0);
        @(negedge ap_clk);
        soft_clr = 1'b1;
        tick();
        soft_clr = 1'b0;
        chk("clr_tap_err", 32'(tap_err), 0);
        chk("clr_pix_cnt", 32'(pix_cnt), 0);
        beat(327680, 1'b0);
        beat(327680, 1'b0);
        beat(327680, 1'b0);
        chk("clr_no_early_pix", 32'(out_valid), 0);
        beat(327680, 1'b1);
        chk("clr_pix_valid", 32'(out_valid), 1);
        chk("clr_pix_data",  32'(out_data),  40);
        chk("clr_no_err",    32'(tap_err),   0);
        tick();
        chk("clr_pix_cnt_1", 32'(pix_cnt), 1);

        // Async reset mid-pixel, asserted away from any clock edge.
        beat(32'h0010_0000, 1'b0);
        beat(32'h0010_0000, 1'b0);
        #2;
        ap_rst_n = 1'b0;
        #1;
        chk("arst_out_data", 32'(out_data), 0);
        chk("arst_pix_cnt",  32'(pix_cnt),  0);
        chk("arst_valid",    32'(out_valid), 0);
        chk("arst_in_ready", 32'(in_ready), 1);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        beat(327680, 1'b0);
        beat(327680, 1'b0);
        beat(327680, 1'b0);
        chk("arst_no_early_pix", 32'(out_valid), 0);
        beat(327680, 1'b1);
        chk("arst_pix_valid", 32'(out_valid), 1);
        chk("arst_pix_data",  32'(out_data),  40);
        chk("arst_tap_err",   32'(tap_err),   0);

        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/resize_accel_bilinear_acc.md
Name: resize_accel_bilinear_acc

Overview:
Downstream consumer of the resize datapath's 16x16 unsigned product stream. Each product is an 8-bit source pixel zero-extended to 16 bits, times a Q1.15 bilinear weight. The block accumulates TAPS products per output pixel, then rounds, shifts and saturates the sum to an OUT_W-bit pixel. It presents the result on a valid/ready stream toward the output packer and flags tap-framing errors.

Parameters:
PROD_W, 32, width of incoming unsigned product
TAPS, 4, products accumulated per output pixel (>=2)
FRAC_BITS, 15, fractional bits of weight; right-shift applied after rounding (>=1)
OUT_W, 8, output pixel width
ACC_W, PROD_W+2, accumulator width (must be >= PROD_W+ceil(log2(TAPS)))

Ports:
ap_clk  in  1  clock, all state on rising edge
ap_rst_n  in  1  asynchronous active-low reset
soft_clr  in  1  synchronous clear of partial pixel and error flag
in_data  in  PROD_W  unsigned product
in_last  in  1  marks final tap of a pixel
in_valid  in  1  product valid
in_ready  out  1  block can accept product
out_data  out  OUT_W  rounded/saturated pixel
out_valid  out  1  pixel valid
out_ready  in  1  downstream accepts pixel
tap_err  out  1  sticky: in_last disagreed with tap count
pix_cnt  out  16  pixels emitted since reset/soft_clr, wraps 0xFFFF->0

Behaviour:
- Reset (ap_rst_n=0, async): acc=0, tap_cnt=0, out_valid=0, out_data=0, tap_err=0, pix_cnt=0. in_ready is combinational and reads 1 after reset.
- Accept: a product is taken when in_valid && in_ready.
- Tap handling:
  - Non-final tap (tap_cnt<TAPS-1): acc <= acc + in_data, tap_cnt++.
  - Final tap (tap_cnt==TAPS-1): sum = acc + in_data.
  - Result: r = (sum + 2^(FRAC_BITS-1)) >> FRAC_BITS; out_data <= (r > 2^OUT_W-1) ? 2^OUT_W-1 : r[OUT_W-1:0].
  - After the final tap: out_valid <= 1, acc <= 0, tap_cnt <= 0.
  - Latency: final tap accepted in cycle N -> out_valid=1 in cycle N+1.
- Rounding and saturation: the round-add is done at ACC_W+1 bits, so there is no wrap before saturation.
- Framing:
  - in_last=1 on a non-final tap, or in_last=0 on the final tap -> tap_err <= 1 (sticky).
  - The tap counter alone defines pixel boundaries; in_last never resets it.
- Output handshake:
  - out_valid && out_ready -> pixel consumed, pix_cnt++.
  - out_valid deasserts unless a new final tap is accepted in the same cycle. In that case out_valid stays 1, out_data takes the new pixel, and pix_cnt still increments.
  - While out_valid && !out_ready, out_data is stable.
- in_ready = !(tap_cnt==TAPS-1 && out_valid && !out_ready). Non-final taps are never back-pressured.
- soft_clr (sync, highest priority over accept):
  - acc=0, tap_cnt=0, tap_err=0, pix_cnt=0, out_valid=0.
  - The in-flight input beat and any pending output are dropped.
- Reset mid-pixel: the partial accumulation is discarded; the next accepted product is tap 0.
- States: ACCUM (tap_cnt 0..TAPS-2), LAST (tap_cnt==TAPS-1), with out_valid as an independent holding flag.

Test Plan:
- Four taps of 255*8192=2088960, last on the 4th, out_ready=1 -> out_data=255 one cycle after the 4th accept, pix_cnt=1, tap_err=0.
- Rounding: taps {16384,0,0,0} -> out_data=1; taps {16383,0,0,0} -> out_data=0.
- Saturation: four taps of 0x00FFFFFF -> out_data=255 (no wrap); tap_err=0.
- Back-pressure: out_ready=0 after the first pixel (value 100). Three more taps are accepted, then in_ready=0 on the 4th tap and out_data holds 100. Raise out_ready -> 100 drains, the 4th tap is accepted, and the second pixel appears next cycle.
- Framing error: in_last=1 on tap 2 -> tap_err=1 and the pixel still completes after 4 taps. soft_clr -> tap_err=0, pix_cnt=0.
- Async reset asserted after 2 taps mid-cycle -> outputs are 0 immediately. Then 4 taps of 32768*10=327680 -> out_data=40.
